// File: rtl/divider_4bit.sv
// Four-bit unsigned restoring divider: one quotient bit per clock through a 5-bit trial subtractor.
// Define DIV_ZERO_DETECT_EN to short-circuit divide-by-zero straight to DONE and raise div_by_zero.
module divider_4bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] dividend,
   input  logic [3:0] divisor,
   output logic [3:0] quotient,
   output logic [3:0] remainder,
   output logic       busy,
   output logic       done,
   output logic       div_by_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state;
   logic [1:0] counter;
   logic [3:0] dvd_r;
   logic [3:0] dvs_r;
   logic [3:0] part_rem;
   logic [3:0] quo_work;

   logic [4:0] shifted;
   logic [5:0] trial;
   logic       borrow;
   logic [3:0] part_rem_next;
   logic [3:0] quo_next;

   // Both truncations to 4 bits are safe: the partial remainder stays below the divisor,
   // and with a zero divisor it simply accumulates the dividend bits.
   always_comb begin
      shifted       = {part_rem, dvd_r[counter]};
      trial         = {1'b0, shifted} - {2'b00, dvs_r};
      borrow        = trial[5];
      part_rem_next = borrow ? shifted[3:0] : trial[3:0];
      quo_next          = quo_work;
      quo_next[counter] = ~borrow;
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);

`ifdef DIV_ZERO_DETECT_EN
   logic dbz_flag;
   assign div_by_zero = dbz_flag;
`else
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         counter   <= 2'd0;
         dvd_r     <= 4'd0;
         dvs_r     <= 4'd0;
         part_rem  <= 4'd0;
         quo_work  <= 4'd0;
         quotient  <= 4'd0;
         remainder <= 4'd0;
`ifdef DIV_ZERO_DETECT_EN
         dbz_flag  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  dvd_r    <= dividend;
                  dvs_r    <= divisor;
                  part_rem <= 4'd0;
                  quo_work <= 4'd0;
                  counter  <= 2'd3;
`ifdef DIV_ZERO_DETECT_EN
                  if (divisor == 4'd0) begin
                     quotient  <= 4'hF;
                     remainder <= dividend;
                     dbz_flag  <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               part_rem <= part_rem_next;
               quo_work <= quo_next;
               counter  <= counter - 2'd1;
               if (counter == 2'd0) begin
                  quotient  <= quo_next;
                  remainder <= part_rem_next;
`ifdef DIV_ZERO_DETECT_EN
                  dbz_flag  <= 1'b0;
`endif
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_4bit.sv
// Bench for divider_4bit: directed scenarios, a full operand sweep and random requests,
// all checked against plain integer division.
module tb_divider_4bit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   divider_4bit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_q(input int dd, input int dv);
      return (dv == 0) ? 15 : dd / dv;
   endfunction

   function automatic int ref_r(input int dd, input int dv);
      return (dv == 0) ? dd : dd % dv;
   endfunction

   function automatic int ref_lat(input int dv);
`ifdef DIV_ZERO_DETECT_EN
      return (dv == 0) ? 0 : 4;
`else
      return 4;
`endif
   endfunction

   function automatic int ref_dbz(input int dv);
`ifdef DIV_ZERO_DETECT_EN
      return (dv == 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns the number of cycles after the accepting edge until done (-1 on timeout).
   // Operands are scrambled every cycle after acceptance so that unaccepted changes are exercised.
   task automatic apply_stimulus(input logic [3:0] dd, input logic [3:0] dv, input int inject_at,
                                 input logic [3:0] idd, input logic [3:0] idv,
                                 output int lat, output int busy_cnt, output logic [3:0] mid_q);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      lat      = -1;
      busy_cnt = 0;
      mid_q    = 4'd0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         start = 1'b0;
         if (j == inject_at) begin
            dividend = idd;
            divisor  = idv;
            start    = 1'b1;
         end else begin
            dividend = 4'($urandom);
            divisor  = 4'($urandom);
         end
         if (busy) busy_cnt++;
         if (j == 2) mid_q = quotient;
         if (done) begin
            lat = j;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input int dd, input int dv, input int lat, input int busy_cnt);
      check_output($sformatf("%s_lat", tag), lat, ref_lat(dv));
      check_output($sformatf("%s_busy", tag), busy_cnt, ref_lat(dv));
      check_output($sformatf("%s_q", tag), quotient, ref_q(dd, dv));
      check_output($sformatf("%s_r", tag), remainder, ref_r(dd, dv));
      check_output($sformatf("%s_dbz", tag), div_by_zero, ref_dbz(dv));
   endtask

   initial begin
      int lat;
      int busy_cnt;
      int seen;
      logic [3:0] mid_q;
      logic [3:0] rdd;
      logic [3:0] rdv;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = 4'd0;
      divisor  = 4'd0;
      repeat (2) @(negedge clk);
      check_output("reset_q", quotient, 0);
      check_output("reset_r", remainder, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_done", done, 0);
      check_output("reset_dbz", div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] 13/3");
      apply_stimulus(4'd13, 4'd3, -1, 4'd0, 4'd0, lat, busy_cnt, mid_q);
      check_result("d13_3", 13, 3, lat, busy_cnt);

      $display("[TB] 15/1 then 2/7 back-to-back");
      @(negedge clk);
      apply_stimulus(4'd15, 4'd1, -1, 4'd0, 4'd0, lat, busy_cnt, mid_q);
      check_result("d15_1", 15, 1, lat, busy_cnt);
      apply_stimulus(4'd2, 4'd7, -1, 4'd0, 4'd0, lat, busy_cnt, mid_q);
      check_output("b2b_hold_q", mid_q, 15);
      check_result("d2_7", 2, 7, lat, busy_cnt);
      @(negedge clk);
      check_output("done_one_cycle", done, 0);
      check_output("idle_busy", busy, 0);

      $display("[TB] 9/0");
      apply_stimulus(4'd9, 4'd0, -1, 4'd0, 4'd0, lat, busy_cnt, mid_q);
      check_result("d9_0", 9, 0, lat, busy_cnt);
      @(negedge clk);

      $display("[TB] 12/5 with ignored 7/2 start");
      apply_stimulus(4'd12, 4'd5, 1, 4'd7, 4'd2, lat, busy_cnt, mid_q);
      check_result("ignore", 12, 5, lat, busy_cnt);
      @(negedge clk);

      $display("[TB] reset abort during 14/3");
      dividend = 4'd14;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("abort_q", quotient, 0);
      check_output("abort_r", remainder, 0);
      check_output("abort_busy", busy, 0);
      check_output("abort_done", done, 0);
      check_output("abort_dbz", div_by_zero, 0);
      #1;
      rst  = 1'b0;
      seen = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check_output("abort_no_done", seen, 0);
      apply_stimulus(4'd14, 4'd3, -1, 4'd0, 4'd0, lat, busy_cnt, mid_q);
      check_result("after_abort", 14, 3, lat, busy_cnt);

      $display("[TB] operand sweep");
      for (int dd = 0; dd < 16; dd++) begin
         for (int dv = 0; dv < 16; dv++) begin
            @(negedge clk);
            apply_stimulus(4'(dd), 4'(dv), -1, 4'd0, 4'd0, lat, busy_cnt, mid_q);
            check_output($sformatf("sw_q_%0d_%0d", dd, dv), quotient, ref_q(dd, dv));
            check_output($sformatf("sw_r_%0d_%0d", dd, dv), remainder, ref_r(dd, dv));
            check_output($sformatf("sw_lat_%0d_%0d", dd, dv), lat, ref_lat(dv));
            if (dv != 0) begin
               check_output($sformatf("sw_id_%0d_%0d", dd, dv), int'(quotient) * dv + int'(remainder), dd);
               check_output($sformatf("sw_lt_%0d_%0d", dd, dv), (int'(remainder) < dv) ? 1 : 0, 1);
            end
         end
      end

      $display("[TB] random requests");
      for (int i = 0; i < 40; i++) begin
         rdd = 4'($urandom);
         rdv = 4'($urandom_range(15, 0));
         if ($urandom_range(1, 0) == 1) @(negedge clk);
         apply_stimulus(rdd, rdv, -1, 4'd0, 4'd0, lat, busy_cnt, mid_q);
         check_result($sformatf("rnd%0d", i), rdd, rdv, lat, busy_cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
